// File: rtl/l2_msg_out_arb.sv
// Outbound L2 message buffer: one FIFO per coherence channel, merged onto a single
// valid/ready NoC port by a round-robin or fixed-priority arbiter with a stall lock.
module l2_msg_out_arb #(
  parameter int NUM_CH    = 3,
  parameter int DEPTH     = 4,
  parameter int MSG_W     = 128,
  parameter int PRIO_MODE = 0,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*MSG_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MSG_W-1:0]          out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic [NUM_CH*CNT_W-1:0]   occupancy,
  output logic                      all_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [MSG_W-1:0] mem_q    [NUM_CH][DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_d    [NUM_CH];

  logic [NUM_CH-1:0] nonempty_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
  logic [CH_W-1:0]   base_s, cand_s, arb_ch_s, grant_s;
  logic [0:0]        state_q, state_d;
  logic              arb_found_s;
  logic              hs_s;

  function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return (sum >= NUM_CH) ? CH_W'(sum - NUM_CH) : CH_W'(sum);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      nonempty_s[c]                    = (cnt_q[c] != {CNT_W{1'b0}});
      in_ready[c]                      = (cnt_q[c] != CNT_W'(DEPTH));
      push_s[c]                        = in_valid[c] && in_ready[c];
      occupancy[c*CNT_W +: CNT_W]      = cnt_q[c];
    end
    all_empty = ~|nonempty_s;
  end

  // Scan starts at the RR pointer, or at channel 0 in fixed-priority mode.
  always_comb begin
    base_s      = (PRIO_MODE == 1) ? {CH_W{1'b0}} : rr_q;
    arb_ch_s    = {CH_W{1'b0}};
    arb_found_s = 1'b0;
    cand_s      = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s = ch_add(base_s, k);
      if (!arb_found_s && nonempty_s[cand_s]) begin
        arb_found_s = 1'b1;
        arb_ch_s    = cand_s;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  always_comb begin
    grant_s   = (state_q == ST_LOCKED) ? lock_ch_q : arb_ch_s;
    out_valid = (state_q == ST_LOCKED) || arb_found_s;
    hs_s      = out_valid && out_ready;
    out_data  = out_valid ? mem_q[grant_s][rd_ptr_q[grant_s]] : {MSG_W{1'b0}};
    out_ch    = out_valid ? grant_s : {CH_W{1'b0}};
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pop_s[c]    = hs_s && (grant_s == CH_W'(c));
      cnt_d[c]    = cnt_q[c];
      rd_ptr_d[c] = pop_s[c] ? ptr_inc(rd_ptr_q[c]) : rd_ptr_q[c];
      wr_ptr_d[c] = push_s[c] ? ptr_inc(wr_ptr_q[c]) : wr_ptr_q[c];
      if (push_s[c] && !pop_s[c]) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end else if (pop_s[c] && !push_s[c]) begin
        cnt_d[c] = cnt_q[c] - CNT_W'(1);
      end else begin
        cnt_d[c] = cnt_q[c];
      end
    end
  end

  // A stalled grant is frozen so the downstream sees a stable message until it accepts.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (out_valid && !out_ready) begin
          state_d   = ST_LOCKED;
          lock_ch_d = grant_s;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (hs_s && (PRIO_MODE == 0)) begin
      rr_d = ch_add(grant_s, 1);
    end else begin
      rr_d = rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= {CH_W{1'b0}};
      rr_q      <= {CH_W{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= {CNT_W{1'b0}};
        rd_ptr_q[c] <= {PTR_W{1'b0}};
        wr_ptr_q[c] <= {PTR_W{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_q      <= rr_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= cnt_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        wr_ptr_q[c] <= wr_ptr_d[c];
      end
    end
  end

  // Payload storage carries no reset; emptiness is tracked by the counters alone.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_s[c]) begin
        mem_q[c][wr_ptr_q[c]] <= in_data[c*MSG_W +: MSG_W];
      end
    end
  end

endmodule

// File: tb/tb_l2_msg_out_arb.sv
// Bench for l2_msg_out_arb: a round-robin and a fixed-priority instance share stimulus;
// a queue-based reference model predicts every output, plus directed sequence checks.
module tb_l2_msg_out_arb;
  localparam int NC = 3;
  localparam int DP = 4;
  localparam int MW = 128;
  localparam int CW = 2;
  localparam int NW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     in_valid;
  logic [NC*MW-1:0]  in_data;
  logic              out_ready;
  logic [NC-1:0]     in_ready_w  [2];
  logic              out_valid_w [2];
  logic [MW-1:0]     out_data_w  [2];
  logic [CW-1:0]     out_ch_w    [2];
  logic [NC*NW-1:0]  occ_w       [2];
  logic              all_empty_w [2];

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  logic [MW-1:0] mq [2][NC][$];
  int            rr_m  [2];
  bit            lk    [2];
  int            lkc   [2];
  int            hs_ch [2][$];
  logic [MW-1:0] hs_dat[2][$];

  always #5 clk = ~clk;

  l2_msg_out_arb #(.NUM_CH(NC), .DEPTH(DP), .MSG_W(MW), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
    .out_ch(out_ch_w[0]), .occupancy(occ_w[0]), .all_empty(all_empty_w[0]));

  l2_msg_out_arb #(.NUM_CH(NC), .DEPTH(DP), .MSG_W(MW), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
    .out_ch(out_ch_w[1]), .occupancy(occ_w[1]), .all_empty(all_empty_w[1]));

  task automatic chk(input string nm, input int m, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", nm, m, act, exp, $time);
    end
  endtask

  // Reference arbitration: lock wins, else scan non-empty queues from rr (mode 0) or from 0 (mode 1).
  function automatic int exp_grant(input int m);
    int start;
    if (lk[m]) return lkc[m];
    start = (m == 0) ? rr_m[m] : 0;
    for (int k = 0; k < NC; k++) begin
      if (mq[m][(start + k) % NC].size() > 0) return (start + k) % NC;
    end
    return -1;
  endfunction

  task automatic check_inst(input int m);
    int g;
    g = exp_grant(m);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("in_ready%0d", c), m, in_ready_w[m][c], (mq[m][c].size() < DP));
      chk($sformatf("occ%0d", c), m, occ_w[m][c*NW +: NW], mq[m][c].size());
    end
    chk("all_empty", m, all_empty_w[m], (mq[m][0].size() + mq[m][1].size() + mq[m][2].size()) == 0);
    chk("out_valid", m, out_valid_w[m], g >= 0);
    if (g >= 0 && out_valid_w[m]) begin
      chk("out_ch", m, out_ch_w[m], g);
      chk("out_data", m, out_data_w[m], mq[m][g][0]);
    end
  endtask

  task automatic update_inst(input int m);
    int g;
    logic [NC-1:0] pu;
    g = exp_grant(m);
    for (int c = 0; c < NC; c++) pu[c] = in_valid[c] && (mq[m][c].size() < DP);
    if (out_valid_w[m] && out_ready) begin
      hs_ch[m].push_back(out_ch_w[m]);
      hs_dat[m].push_back(out_data_w[m]);
    end
    if (g >= 0 && out_ready) begin
      void'(mq[m][g].pop_front());
      lk[m]   = 1'b0;
      rr_m[m] = (g + 1) % NC;
    end else if (g >= 0) begin
      lk[m]  = 1'b1;
      lkc[m] = g;
    end
    for (int c = 0; c < NC; c++) if (pu[c]) mq[m][c].push_back(in_data[c*MW +: MW]);
  endtask

  // Monitor: inputs are stable at the falling edge; compare, then advance the model.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (armed) check_inst(m);
      if (rst) begin
        for (int c = 0; c < NC; c++) mq[m][c].delete();
        rr_m[m] = 0;
        lk[m]   = 1'b0;
        lkc[m]  = 0;
      end else if (armed) begin
        update_inst(m);
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int m = 0; m < 2; m++) begin
      hs_ch[m].delete();
      hs_dat[m].delete();
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NC*MW/32; i++) in_data[i*32 +: 32] = $urandom;
  endtask

  int exp_seq [2][6];
  int thr;

  initial begin
    exp_seq[0] = '{0, 1, 2, 0, 1, 2};
    exp_seq[1] = '{0, 0, 1, 1, 2, 2};
    rst = 1'b1; in_valid = 3'b111; out_ready = 1'b0; rand_data();
    step(); step();
    rst = 1'b0; in_valid = 3'b000;
    for (int m = 0; m < 2; m++) begin
      chk("rst_in_ready", m, in_ready_w[m], 3'b111);
      chk("rst_out_valid", m, out_valid_w[m], 1'b0);
      chk("rst_all_empty", m, all_empty_w[m], 1'b1);
    end

    // Fill channel 1 to DEPTH, then drain in order
    in_valid = 3'b010;
    for (int i = 1; i <= 4; i++) begin
      in_data = '0;
      in_data[MW +: 8] = 8'hA0 + 8'(i);
      step();
    end
    in_valid = 3'b000;
    for (int m = 0; m < 2; m++) begin
      chk("full_in_ready1", m, in_ready_w[m][1], 1'b0);
      chk("full_occ1", m, occ_w[m][NW +: NW], 3'd4);
    end
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("drain_len", m, hs_dat[m].size(), 4);
      for (int i = 0; i < 4 && i < hs_dat[m].size(); i++)
        chk($sformatf("drain_data%0d", i), m, hs_dat[m][i], 128'hA1 + 128'(i));
    end

    // Two messages per channel: RR gives 0,1,2,0,1,2; fixed priority gives 0,0,1,1,2,2
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 3'b111;
    rand_data(); step();
    rand_data(); step();
    in_valid = 3'b000;
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("arb_len", m, hs_ch[m].size(), 6);
      for (int i = 0; i < 6 && i < hs_ch[m].size(); i++)
        chk($sformatf("arb_ch%0d", i), m, hs_ch[m][i], exp_seq[m][i]);
    end

    // Lock: ch2 stalled, ch0 arrives; grant must stay on ch2 until the handshake
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 3'b100; rand_data(); step();
    in_valid = 3'b000; step();
    in_valid = 3'b001; rand_data(); step();
    in_valid = 3'b000; step(); step();
    for (int m = 0; m < 2; m++) begin
      chk("lock_valid", m, out_valid_w[m], 1'b1);
      chk("lock_ch", m, out_ch_w[m], 2'd2);
    end
    clear_logs();
    out_ready = 1'b1; step(); step();
    out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("lock_len", m, hs_ch[m].size(), 2);
      if (hs_ch[m].size() >= 2) begin
        chk("lock_first", m, hs_ch[m][0], 2);
        chk("lock_next", m, hs_ch[m][1], 0);
      end
    end

    // Push and pop on ch0 at occupancy 3, then reset in the middle of a stall
    rst = 1'b1; step(); rst = 1'b0;
    in_valid = 3'b001;
    for (int i = 0; i < 3; i++) begin rand_data(); step(); end
    in_valid = 3'b000;
    for (int m = 0; m < 2; m++) chk("occ_before", m, occ_w[m][NW-1:0], 3'd3);
    in_valid = 3'b001; out_ready = 1'b1; rand_data(); step();
    in_valid = 3'b000; out_ready = 1'b0;
    for (int m = 0; m < 2; m++) chk("occ_pushpop", m, occ_w[m][NW-1:0], 3'd3);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("midrst_valid", m, out_valid_w[m], 1'b0);
      chk("midrst_occ", m, occ_w[m], 9'd0);
    end

    // Random traffic with varying backpressure
    for (int cyc = 0; cyc < 3000; cyc++) begin
      thr = (cyc < 1000) ? 30 : ((cyc < 2000) ? 70 : 95);
      in_valid  = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 99) < thr);
      rand_data();
      step();
    end
    in_valid = 3'b000; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    for (int m = 0; m < 2; m++) chk("final_empty", m, all_empty_w[m], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
